// File: rtl/rom_arbiter.sv
// Shares one memory read port between PRG (CPU) and CHR (PPU) fetches.
// CHR has fixed priority; a starvation counter forces a PRG grant after STARVE CHR grants.
module rom_arbiter #(
  parameter int unsigned STARVE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  prgsize,
  input  logic [20:0] promaddr,
  input  logic        promreq,
  output logic        promack,
  output logic [7:0]  promdata,
  input  logic [20:0] cromaddr,
  input  logic        cromreq,
  output logic        cromack,
  output logic [7:0]  cromdata,
  output logic [21:0] memaddr,
  output logic        memreq,
  input  logic        memack,
  input  logic [7:0]  memrdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  localparam logic [3:0] StarveLim = 4'(STARVE);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_chr_q, sel_chr_d;
  logic        memreq_q, memreq_d;
  logic [21:0] memaddr_q, memaddr_d;
  logic        promack_q, promack_d;
  logic        cromack_q, cromack_d;
  logic [7:0]  promdata_q, promdata_d;
  logic [7:0]  cromdata_q, cromdata_d;

  logic [21:0] chr_addr;
  logic        grant_chr;

  // CHR lives directly after PRG; overflow past 4 MiB wraps silently.
  assign chr_addr  = {prgsize, 14'b0} + {1'b0, cromaddr};
  assign grant_chr = cromreq && !(promreq && (cnt_q == StarveLim));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_chr_d  = sel_chr_q;
    memreq_d   = memreq_q;
    memaddr_d  = memaddr_q;
    promack_d  = 1'b0;
    cromack_d  = 1'b0;
    promdata_d = promdata_q;
    cromdata_d = cromdata_q;
    unique case (state_q)
      StIdle: begin
        if (!promreq) cnt_d = '0;
        if (cromreq || promreq) begin
          memreq_d = 1'b1;
          state_d  = StBusy;
          if (grant_chr) begin
            sel_chr_d = 1'b1;
            memaddr_d = chr_addr;
            if (promreq && (cnt_q != StarveLim)) cnt_d = cnt_q + 4'd1;
          end else begin
            sel_chr_d = 1'b0;
            memaddr_d = {1'b0, promaddr};
            cnt_d     = '0;
          end
        end
      end
      StBusy: begin
        if (memack) begin
          memreq_d = 1'b0;
          state_d  = StAck;
          if (sel_chr_q) begin
            cromack_d  = 1'b1;
            cromdata_d = memrdata;
          end else begin
            promack_d  = 1'b1;
            promdata_d = memrdata;
          end
        end
      end
      StAck: begin
        // Requests are ignored here so a held req is re-sampled as a fresh one.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_chr_q  <= 1'b0;
      memreq_q   <= 1'b0;
      memaddr_q  <= '0;
      promack_q  <= 1'b0;
      cromack_q  <= 1'b0;
      promdata_q <= '0;
      cromdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_chr_q  <= sel_chr_d;
      memreq_q   <= memreq_d;
      memaddr_q  <= memaddr_d;
      promack_q  <= promack_d;
      cromack_q  <= cromack_d;
      promdata_q <= promdata_d;
      cromdata_q <= cromdata_d;
    end
  end

  assign memreq   = memreq_q;
  assign memaddr  = memaddr_q;
  assign promack  = promack_q;
  assign cromack  = cromack_q;
  assign promdata = promdata_q;
  assign cromdata = cromdata_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: requester drivers, a memory model and an ack monitor.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  prgsize;
  logic [20:0] promaddr;
  logic        promreq;
  logic        promack;
  logic [7:0]  promdata;
  logic [20:0] cromaddr;
  logic        cromreq;
  logic        cromack;
  logic [7:0]  cromdata;
  logic [21:0] memaddr;
  logic        memreq;
  logic        memack;
  logic [7:0]  memrdata;

  rom_arbiter #(.STARVE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .prgsize  (prgsize),
    .promaddr (promaddr),
    .promreq  (promreq),
    .promack  (promack),
    .promdata (promdata),
    .cromaddr (cromaddr),
    .cromreq  (cromreq),
    .cromack  (cromack),
    .cromdata (cromdata),
    .memaddr  (memaddr),
    .memreq   (memreq),
    .memack   (memack),
    .memrdata (memrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chr;
    logic [21:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  logic [20:0] prg_q[$];
  logic [20:0] chr_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          lat      = 3;
  int          n_pack   = 0;
  int          n_cack   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_txn(input logic chr, input logic [21:0] a, input logic [7:0] d);
    exp_t e;
    e.chr  = chr;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(posedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
    prg_q.delete();
    chr_q.delete();
    repeat (3) @(posedge clk);
  endtask

  // Requesters: hold req until ack, then present the next queued address or drop.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (promreq && promack) begin
        prg_q.delete(0);
        promreq = 1'b0;
      end
      if (!promreq && prg_q.size() > 0) begin
        promaddr = prg_q[0];
        promreq  = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (cromreq && cromack) begin
        chr_q.delete(0);
        cromreq = 1'b0;
      end
      if (!cromreq && chr_q.size() > 0) begin
        cromaddr = chr_q[0];
        cromreq  = 1'b1;
      end
    end
  end

  // Memory model: answers after lat cycles unless memreq is withdrawn (cancel).
  initial begin
    memack   = 1'b0;
    memrdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (memreq && !reset) begin
        for (int n = 0; n < lat; n++) begin
          @(posedge clk); #1;
          if (!memreq) break;
        end
        if (memreq) begin
          memack   = 1'b1;
          memrdata = (exp_q.size() > 0) ? exp_q[0].data : 8'h00;
          @(posedge clk); #1;
          memack   = 1'b0;
        end
      end
    end
  end

  // Monitor: checks grant address on memreq rise and each ack against the scoreboard head.
  logic memreq_prev = 1'b0;
  logic ack_prev    = 1'b0;
  always @(negedge clk) begin
    if (memreq && !memreq_prev) begin
      if (exp_q.size() == 0) check("unexpected_memreq", 32'(memaddr), 32'hFFFF_FFFF);
      else check("memaddr", 32'(memaddr), 32'(exp_q[0].addr));
    end
    if (promack || cromack) begin
      check("ack_exclusive", 32'(promack && cromack), 0);
      check("ack_one_cycle", 32'(ack_prev), 0);
      if (promack) n_pack++;
      if (cromack) n_cack++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        check("ack_is_chr", 32'(cromack), 32'(exp_q[0].chr));
        check("ack_data", 32'(cromack ? cromdata : promdata), 32'(exp_q[0].data));
        exp_q.delete(0);
      end
    end
    memreq_prev <= memreq;
    ack_prev    <= promack || cromack;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    prgsize  = 8'd2;
    promaddr = '0;
    promreq  = 1'b0;
    cromaddr = '0;
    cromreq  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_memreq",   32'(memreq),   0);
    check("rst_memaddr",  32'(memaddr),  0);
    check("rst_promack",  32'(promack),  0);
    check("rst_cromack",  32'(cromack),  0);
    check("rst_promdata", 32'(promdata), 0);
    check("rst_cromdata", 32'(cromdata), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // PRG alone
    lat = 3;
    expect_txn(1'b0, 22'h001234, 8'hA5);
    prg_q.push_back(21'h01234);
    drain("drain_prg_alone");
    @(negedge clk);
    check("prg_alone_promdata", 32'(promdata), 32'hA5);

    // CHR offset after 32 KiB of PRG
    lat = 1;
    expect_txn(1'b1, 22'h008010, 8'h3C);
    chr_q.push_back(21'h00010);
    drain("drain_chr_offset");
    @(negedge clk);
    check("chr_offset_cromdata", 32'(cromdata), 32'h3C);

    // Simultaneous: CHR first, then PRG
    lat = 2;
    expect_txn(1'b1, 22'h008020, 8'h22);
    expect_txn(1'b0, 22'h000100, 8'h11);
    prg_q.push_back(21'h00100);
    chr_q.push_back(21'h00020);
    drain("drain_simultaneous");

    // Starvation: 4 CHR, forced PRG, counter cleared so CHR wins next, then PRG
    for (int i = 1; i <= 4; i++) expect_txn(1'b1, 22'h008000 + 22'(i), 8'h80 + 8'(i));
    expect_txn(1'b0, 22'h000200, 8'h77);
    expect_txn(1'b1, 22'h008005, 8'h85);
    expect_txn(1'b0, 22'h000300, 8'h99);
    for (int i = 1; i <= 5; i++) chr_q.push_back(21'(i));
    prg_q.push_back(21'h00200);
    prg_q.push_back(21'h00300);
    drain("drain_starvation");

    // Address wrap past 4 MiB
    prgsize = 8'hFF;
    expect_txn(1'b1, 22'h1FBFFF, 8'hE7);
    chr_q.push_back(21'h1FFFFF);
    drain("drain_wrap");
    prgsize = 8'd2;
    @(negedge clk);
    check("promdata_holds", 32'(promdata), 32'h99);
    check("cromdata_wrap",  32'(cromdata), 32'hE7);

    // Reset while BUSY cancels the request with no ack
    lat = 8;
    expect_txn(1'b0, 22'h000500, 8'h42);
    prg_q.push_back(21'h00500);
    for (int i = 0; i < 50 && !memreq; i++) @(posedge clk);
    check("busy_reached", 32'(memreq), 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstbusy_memreq",  32'(memreq),  0);
    check("rstbusy_memaddr", 32'(memaddr), 0);
    check("rstbusy_promack", 32'(promack), 0);
    prg_q.delete();
    promreq = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rstbusy_promdata", 32'(promdata), 0);
    reset = 1'b0;
    repeat (12) @(posedge clk);

    // New request after reset completes normally
    lat = 2;
    expect_txn(1'b1, 22'h008040, 8'h5D);
    chr_q.push_back(21'h00040);
    drain("drain_after_reset");

    check("prg_ack_count", 32'(n_pack), 4);
    check("chr_ack_count", 32'(n_cack), 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
